// File: rtl/i2c_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// i2c_pkg - command, state and phase encodings for i2c_bit_ctrl.  Rev 1.0
// ------------------------------------------------------------------------
package i2c_pkg;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_READ  = 3'd4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_STOP  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  localparam logic [2:0] PH_A = 3'd0;
  localparam logic [2:0] PH_B = 3'd1;
  localparam logic [2:0] PH_C = 3'd2;
  localparam logic [2:0] PH_D = 3'd3;
  localparam logic [2:0] PH_E = 3'd4;

  function automatic logic [2:0] last_phase(input logic [2:0] st);
    return (st == ST_START) ? PH_E : PH_D;
  endfunction

  // Returns {scl, sda} release values for a given command phase.
  function automatic logic [1:0] phase_lines(input logic [2:0] st, input logic [2:0] ph,
                                             input logic d, input logic hold_scl);
    logic [1:0] lines;
    lines = 2'b11;
    case (st)
      ST_START: begin
        case (ph)
          PH_A:       lines = {hold_scl, 1'b1};
          PH_B:       lines = 2'b11;
          PH_C, PH_D: lines = 2'b10;
          default:    lines = 2'b00;
        endcase
      end
      ST_STOP: begin
        case (ph)
          PH_A:       lines = 2'b00;
          PH_B, PH_C: lines = 2'b10;
          default:    lines = 2'b11;
        endcase
      end
      ST_WRITE, ST_READ: lines = {(ph == PH_B) || (ph == PH_C), d};
      default:           lines = 2'b11;
    endcase
    return lines;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_phase_timer.sv
`default_nettype none
// ------------------------------------------------------------------------
// i2c_phase_timer - phase down-counter with stretch freeze.  Rev 1.0
// ------------------------------------------------------------------------
module i2c_phase_timer #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic             load,
  input  logic [PRE_W-1:0] load_val,
  input  logic             freeze,
  output logic             phase_end
);

  logic [PRE_W-1:0] count;

  assign phase_end = run & ~freeze & (count == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && !freeze && (count != '0)) begin
      count <= count - PRE_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_bit_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// i2c_bit_ctrl - I2C master bit-level command sequencer.  Rev 1.0
// ------------------------------------------------------------------------
module i2c_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [PRE_W-1:0] prescale,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic             cmd_din,
  output logic             cmd_ready,
  output logic             done,
  output logic             dout,
  output logic             al,
  output logic             owner,
  input  logic             scl_i,
  input  logic             sda_i,
  input  logic             sta_det,
  input  logic             sto_det,
  input  logic             bus_busy,
  output logic             scl_o,
  output logic             sda_o
);

  logic [2:0]       state, state_nx, phase, phase_nx;
  logic             data_q, data_nx, hold_q, hold_nx;
  logic [PRE_W-1:0] pre_q;
  logic             accept, active, last, freeze, phase_end, arb_lost, timer_load;
  logic             done_nx, al_nx, dout_nx, owner_nx;
  logic [1:0]       lines_nx;
  logic             unused;

  assign unused    = sta_det;
  assign cmd_ready = (state == ST_IDLE) & ~(bus_busy & ~owner);
  assign accept    = cmd_valid & cmd_ready;
  assign active    = (state != ST_IDLE);
  assign last      = (phase == last_phase(state));
  assign freeze    = scl_o & ~scl_i;
  assign data_nx   = accept ? ((cmd == CMD_READ) | cmd_din) : data_q;
  assign hold_nx   = accept ? scl_o : hold_q;

  // READ keeps SDA released, so a low SDA there is slave data, not a lost arbitration.
  assign arb_lost = ((state == ST_WRITE) && ((phase == PH_B) || (phase == PH_C)) &&
                     phase_end && sda_o && !sda_i) ||
                    (sto_det && owner && (state != ST_STOP));

  assign timer_load = accept | (active & phase_end & ~last);

  i2c_phase_timer #(.PRE_W(PRE_W)) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .run       (active),
    .load      (timer_load),
    .load_val  (accept ? prescale : pre_q),
    .freeze    (freeze),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      phase  <= PH_A;
      data_q <= 1'b1;
      hold_q <= 1'b1;
      pre_q  <= '0;
      scl_o  <= 1'b1;
      sda_o  <= 1'b1;
      done   <= 1'b0;
      al     <= 1'b0;
      dout   <= 1'b0;
      owner  <= 1'b0;
    end else begin
      state  <= state_nx;
      phase  <= phase_nx;
      data_q <= data_nx;
      hold_q <= hold_nx;
      pre_q  <= accept ? prescale : pre_q;
      scl_o  <= lines_nx[1];
      sda_o  <= lines_nx[0];
      done   <= done_nx;
      al     <= al_nx;
      dout   <= dout_nx;
      owner  <= owner_nx;
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    if (arb_lost) begin
      state_nx = ST_IDLE;
      phase_nx = PH_A;
    end else if (accept) begin
      phase_nx = PH_A;
      case (cmd)
        CMD_START: state_nx = ST_START;
        CMD_STOP:  state_nx = ST_STOP;
        CMD_WRITE: state_nx = ST_WRITE;
        CMD_READ:  state_nx = ST_READ;
        default:   state_nx = ST_IDLE;
      endcase
    end else if (active && phase_end) begin
      if (last) begin
        state_nx = ST_IDLE;
        phase_nx = PH_A;
      end else begin
        phase_nx = phase + 3'd1;
      end
    end
  end

  always_comb begin
    done_nx  = 1'b0;
    al_nx    = arb_lost;
    dout_nx  = dout;
    owner_nx = owner;
    lines_nx = {scl_o, sda_o};
    if (arb_lost) begin
      owner_nx = 1'b0;
      lines_nx = 2'b11;
    end else begin
      if (accept && (state_nx == ST_IDLE)) begin
        done_nx = 1'b1;
      end
      if (active && phase_end && last) begin
        done_nx = 1'b1;
        if (state == ST_START) owner_nx = 1'b1;
        if (state == ST_STOP)  owner_nx = 1'b0;
      end
      if ((state == ST_READ) && (phase == PH_C) && phase_end) begin
        dout_nx = sda_i;
      end
      // Idle holds the last phase's lines so SCL stays low between bits.
      if (state_nx != ST_IDLE) begin
        lines_nx = phase_lines(state_nx, phase_nx, data_nx, hold_nx);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_bit_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_i2c_bit_ctrl - self-checking bench for i2c_bit_ctrl.  Rev 1.0
// ------------------------------------------------------------------------
module tb_i2c_bit_ctrl;
  import i2c_pkg::*;

  localparam int PRE_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [PRE_W-1:0] prescale = '0;
  logic             cmd_valid = 1'b0;
  logic [2:0]       cmd = CMD_NOP;
  logic             cmd_din = 1'b0;
  logic             cmd_ready, done, dout, al, owner, scl_o, sda_o;
  logic             scl_i, sda_i;
  logic             sta_det = 1'b0, sto_det = 1'b0, bus_busy = 1'b0;
  logic             stretch = 1'b0, slave_low = 1'b0;

  assign scl_i = scl_o & ~stretch;
  assign sda_i = sda_o & ~slave_low;

  i2c_bit_ctrl #(.PRE_W(PRE_W)) dut (
    .clk(clk), .rstn(rstn), .prescale(prescale), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_din(cmd_din), .cmd_ready(cmd_ready), .done(done), .dout(dout), .al(al),
    .owner(owner), .scl_i(scl_i), .sda_i(sda_i), .sta_det(sta_det), .sto_det(sto_det),
    .bus_busy(bus_busy), .scl_o(scl_o), .sda_o(sda_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_al;
    int at;
    bit chk_dout;
    bit dv;
  } exp_t;

  typedef struct {
    logic [2:0] c;
    logic       d;
    int         pre;
    int         n;
    bit         rd;
    bit         dv;
  } vec_t;

  exp_t       sb[$];
  int         checks = 0, errors = 0;
  logic [2:0] cur_cmd = CMD_NOP;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // One cycle: wait past the falling edge, then score any done/al event.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    #1;
    if (rstn && (done || al)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", 32'(done | al), 0);
      end else begin
        e = sb.pop_front();
        chk("event_is_al", al, e.is_al);
        chk("event_cycle", cyc, e.at);
        if (done && !bus_busy) chk("ready_in_done", cmd_ready, 1);
        if (done && e.chk_dout) chk("read_dout", dout, e.dv);
      end
    end
    if (rstn && prev_scl && scl_o && (sda_o !== prev_sda)) begin
      chk("sda_edge_scl_high",
          ((cur_cmd == CMD_START) && !sda_o) || ((cur_cmd == CMD_STOP) && sda_o), 1);
    end
    prev_scl = scl_o;
    prev_sda = sda_o;
  endtask

  task automatic issue(input logic [2:0] c, input logic d, input int pre, input bit slv,
                       input exp_t ev, output int acc);
    int w = 0;
    while (!cmd_ready && w < 500) begin
      tick();
      w++;
    end
    chk("ready_before_issue", cmd_ready, 1);
    slave_low = slv;
    cur_cmd   = c;
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_din   = d;
    prescale  = PRE_W'(pre);
    acc       = cyc;
    ev.at     = cyc + ev.at;
    sb.push_back(ev);
    tick();
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    cmd_din   = 1'($urandom_range(0, 1));
    prescale  = PRE_W'($urandom_range(0, 7));
  endtask

  task automatic wait_idle();
    int w = 0;
    while (sb.size() > 0 && w < 2000) begin
      tick();
      w++;
    end
    if (sb.size() > 0) begin
      chk("event_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic lines_at(input int at, input logic s, input logic d, input string nm);
    int w = 0;
    while (cyc < at && w < 1000) begin
      tick();
      w++;
    end
    chk({nm, "_scl"}, scl_o, s);
    chk({nm, "_sda"}, sda_o, d);
  endtask

  function automatic exp_t mk(input bit is_al, input int off, input bit rd, input bit dv);
    exp_t e;
    e.is_al = is_al;
    e.at = off;
    e.chk_dout = rd;
    e.dv = dv;
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v[11];
    int   acc, prev_done;
    exp_t ev;

    v[0]  = '{CMD_START, 1'b0, 0, 5, 1'b0, 1'b0};
    v[1]  = '{CMD_WRITE, 1'b1, 0, 4, 1'b0, 1'b0};
    v[2]  = '{CMD_WRITE, 1'b0, 0, 4, 1'b0, 1'b0};
    v[3]  = '{CMD_WRITE, 1'b1, 2, 4, 1'b0, 1'b0};
    v[4]  = '{CMD_READ,  1'b0, 0, 4, 1'b1, 1'b0};
    v[5]  = '{CMD_READ,  1'b0, 1, 4, 1'b1, 1'b1};
    v[6]  = '{CMD_NOP,   1'b0, 0, 0, 1'b0, 1'b0};
    v[7]  = '{CMD_WRITE, 1'b0, 1, 4, 1'b0, 1'b0};
    v[8]  = '{CMD_START, 1'b0, 1, 5, 1'b0, 1'b0};
    v[9]  = '{CMD_READ,  1'b1, 3, 4, 1'b1, 1'b0};
    v[10] = '{CMD_STOP,  1'b0, 0, 4, 1'b0, 1'b0};

    // Reset state
    tick();
    chk("rst_scl", scl_o, 1);
    chk("rst_sda", sda_o, 1);
    chk("rst_done", done, 0);
    chk("rst_al", al, 0);
    chk("rst_dout", dout, 0);
    chk("rst_owner", owner, 0);
    chk("rst_ready", cmd_ready, 1);
    rstn = 1'b1;
    tick();

    // START then STOP, prescale=3, with phase snapshots
    issue(CMD_START, 1'b0, 3, 1'b0, mk(0, 21, 0, 0), acc);
    lines_at(acc + 4, 1, 1, "start_a");
    lines_at(acc + 8, 1, 1, "start_b");
    lines_at(acc + 9, 1, 0, "start_c");
    lines_at(acc + 17, 0, 0, "start_e");
    wait_idle();
    chk("owner_after_start", owner, 1);
    issue(CMD_STOP, 1'b0, 3, 1'b0, mk(0, 17, 0, 0), acc);
    lines_at(acc + 4, 0, 0, "stop_a");
    lines_at(acc + 5, 1, 0, "stop_b");
    lines_at(acc + 13, 1, 1, "stop_d");
    wait_idle();
    chk("owner_after_stop", owner, 0);

    // Back-to-back command table
    prev_done = 0;
    for (int i = 0; i < 11; i++) begin
      ev = mk(0, v[i].n * (v[i].pre + 1) + 1, v[i].rd, v[i].dv);
      issue(v[i].c, v[i].d, v[i].pre, v[i].rd && !v[i].dv, ev, acc);
      if (i > 0) chk("back_to_back_accept", acc, prev_done);
      prev_done = acc + ev.at;
    end
    wait_idle();

    // Slave stretches SCL for 40 cycles in WRITE phase B
    issue(CMD_START, 1'b0, 0, 1'b0, mk(0, 6, 0, 0), acc);
    wait_idle();
    issue(CMD_WRITE, 1'b0, 0, 1'b0, mk(0, 45, 0, 0), acc);
    stretch = 1'b1;
    lines_at(acc + 2, 1, 0, "stretch_b_first");
    lines_at(acc + 41, 1, 0, "stretch_b_last");
    lines_at(acc + 42, 1, 0, "stretch_b_release");
    stretch = 1'b0;
    lines_at(acc + 43, 1, 0, "stretch_c");
    lines_at(acc + 44, 0, 0, "stretch_d");
    wait_idle();

    // Arbitration lost: another master pulls SDA low while we send 1
    issue(CMD_WRITE, 1'b1, 1, 1'b1, mk(1, 5, 0, 0), acc);
    lines_at(acc + 3, 1, 1, "arb_b");
    wait_idle();
    chk("arb_scl_released", scl_o, 1);
    chk("arb_sda_released", sda_o, 1);
    chk("arb_owner", owner, 0);
    slave_low = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Foreign STOP while we own the bus
    issue(CMD_START, 1'b0, 0, 1'b0, mk(0, 6, 0, 0), acc);
    wait_idle();
    sto_det = 1'b1;
    sb.push_back(mk(1, cyc + 1, 0, 0));
    tick();
    sto_det = 1'b0;
    chk("sto_al_owner", owner, 0);
    chk("sto_al_scl", scl_o, 1);

    // Asynchronous reset mid-WRITE
    issue(CMD_START, 1'b0, 0, 1'b0, mk(0, 6, 0, 0), acc);
    wait_idle();
    issue(CMD_WRITE, 1'b0, 3, 1'b0, mk(0, 17, 0, 0), acc);
    lines_at(acc + 6, 1, 0, "pre_reset");
    rstn = 1'b0;
    #1;
    chk("async_rst_scl", scl_o, 1);
    chk("async_rst_sda", sda_o, 1);
    chk("async_rst_owner", owner, 0);
    sb.delete();
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // START held off while another master owns the bus
    bus_busy  = 1'b1;
    cur_cmd   = CMD_START;
    cmd_valid = 1'b1;
    cmd       = CMD_START;
    prescale  = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("busy_ready_low", cmd_ready, 0);
      chk("busy_sda_idle", sda_o, 1);
    end
    bus_busy = 1'b0;
    #1;
    chk("busy_release_ready", cmd_ready, 1);
    sb.push_back(mk(0, cyc + 6, 0, 0));
    tick();
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    bus_busy  = 1'b1;
    wait_idle();
    chk("owner_busy_owner", owner, 1);
    chk("owner_busy_ready", cmd_ready, 1);
    issue(CMD_STOP, 1'b0, 0, 1'b0, mk(0, 5, 0, 0), acc);
    wait_idle();
    chk("stop_busy_owner", owner, 0);
    chk("stop_busy_ready", cmd_ready, 0);
    bus_busy = 1'b0;
    #1;
    chk("idle_ready", cmd_ready, 1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
